// File: rtl/conn_table.sv
// Connection table: hashes a 104-bit flow key into a 2^HASH_LEN entry table,
// linearly probes for a matching or free slot, and returns the slot index as
// the connection id (16'hFFFF when every slot is taken by other keys).
module conn_table #(
  parameter int HASH_LEN = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] tuple_data_i,
  input  logic         tuple_valid_i,
  output logic [15:0]  conn_data_o,
  output logic         conn_valid_o,
  output logic [31:0]  lookup_cnt,
  output logic [31:0]  insert_cnt,
  output logic [31:0]  full_cnt
);

  localparam int DEPTH   = 1 << HASH_LEN;
  localparam int KEY_W   = 104;
  localparam int N_CHUNK = (KEY_W + HASH_LEN - 1) / HASH_LEN;
  localparam int PAD_W   = N_CHUNK * HASH_LEN;

  typedef enum logic [1:0] {
    IDLE,
    HASH,
    PROBE,
    RELEASE
  } state_t;

  state_t               state_q, state_d;
  logic [KEY_W-1:0]     key_q, key_d;
  logic [HASH_LEN-1:0]  idx_q, idx_d;
  logic [HASH_LEN-1:0]  probe_cnt_q, probe_cnt_d;
  logic [15:0]          conn_data_q, conn_data_d;
  logic                 conn_valid_q, conn_valid_d;
  logic [31:0]          lookup_cnt_q, lookup_cnt_d;
  logic [31:0]          insert_cnt_q, insert_cnt_d;
  logic [31:0]          full_cnt_q, full_cnt_d;
  logic [DEPTH-1:0]     valid_q, valid_d;
  logic [KEY_W-1:0]     table_key [DEPTH];

  logic [PAD_W-1:0]     key_pad;
  logic [HASH_LEN-1:0]  hash_idx;
  logic                 entry_hit;
  logic                 entry_empty;
  logic                 last_probe;
  logic                 wr_en;

  // The top 24 bits of the tuple carry no key information.
  logic unused_tuple_bits;
  assign unused_tuple_bits = ^tuple_data_i[127:104];

  assign conn_data_o  = conn_data_q;
  assign conn_valid_o = conn_valid_q;
  assign lookup_cnt   = lookup_cnt_q;
  assign insert_cnt   = insert_cnt_q;
  assign full_cnt     = full_cnt_q;

  // Fold the zero-padded latched key into HASH_LEN-bit chunks and XOR them.
  always_comb begin
    key_pad  = PAD_W'(key_q);
    hash_idx = '0;
    for (int i = 0; i < N_CHUNK; i++) begin
      hash_idx = hash_idx ^ key_pad[i*HASH_LEN +: HASH_LEN];
    end
  end

  assign entry_hit   = valid_q[idx_q] && (table_key[idx_q] == key_q);
  assign entry_empty = !valid_q[idx_q];
  assign last_probe  = (probe_cnt_q == '1);

  // Next-state logic: lookup FSM, probe pointer, result strobe and counters.
  always_comb begin
    state_d      = state_q;
    key_d        = key_q;
    idx_d        = idx_q;
    probe_cnt_d  = probe_cnt_q;
    conn_data_d  = conn_data_q;
    conn_valid_d = 1'b0;
    lookup_cnt_d = lookup_cnt_q;
    insert_cnt_d = insert_cnt_q;
    full_cnt_d   = full_cnt_q;
    valid_d      = valid_q;
    wr_en        = 1'b0;
    case (state_q)
      IDLE: begin
        if (tuple_valid_i) begin
          key_d        = tuple_data_i[KEY_W-1:0];
          lookup_cnt_d = lookup_cnt_q + 32'd1;
          probe_cnt_d  = '0;
          state_d      = HASH;
        end
      end
      HASH: begin
        idx_d   = hash_idx;
        state_d = PROBE;
      end
      PROBE: begin
        if (entry_hit) begin
          conn_data_d  = 16'(idx_q);
          conn_valid_d = 1'b1;
          state_d      = RELEASE;
        end else if (entry_empty) begin
          valid_d[idx_q] = 1'b1;
          wr_en          = 1'b1;
          insert_cnt_d   = insert_cnt_q + 32'd1;
          conn_data_d    = 16'(idx_q);
          conn_valid_d   = 1'b1;
          state_d        = RELEASE;
        end else if (last_probe) begin
          conn_data_d  = 16'hFFFF;
          conn_valid_d = 1'b1;
          full_cnt_d   = full_cnt_q + 32'd1;
          state_d      = RELEASE;
        end else begin
          idx_d       = idx_q + 1'b1;
          probe_cnt_d = probe_cnt_q + 1'b1;
        end
      end
      RELEASE: begin
        if (!tuple_valid_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, outputs, counters and entry valid bits, all cleared by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      key_q        <= '0;
      idx_q        <= '0;
      probe_cnt_q  <= '0;
      conn_data_q  <= '0;
      conn_valid_q <= 1'b0;
      lookup_cnt_q <= '0;
      insert_cnt_q <= '0;
      full_cnt_q   <= '0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      idx_q        <= idx_d;
      probe_cnt_q  <= probe_cnt_d;
      conn_data_q  <= conn_data_d;
      conn_valid_q <= conn_valid_d;
      lookup_cnt_q <= lookup_cnt_d;
      insert_cnt_q <= insert_cnt_d;
      full_cnt_q   <= full_cnt_d;
      valid_q      <= valid_d;
    end
  end

  // Key storage; contents only matter where the valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      table_key[idx_q] <= key_q;
    end
  end

endmodule

// File: tb/tb_conn_table.sv
// Scoreboard bench for conn_table: stimulus pushes the expected id and the
// cycle it is due on; a monitor pops and compares on every result strobe.
module tb_conn_table;

  localparam int HASH_LEN = 6;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [127:0] tuple_data_i = '0;
  logic         tuple_valid_i = 1'b0;
  logic [15:0]  conn_data_o;
  logic         conn_valid_o;
  logic [31:0]  lookup_cnt;
  logic [31:0]  insert_cnt;
  logic [31:0]  full_cnt;

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   strobes = 0;
  int   strobes_before;
  logic [103:0] a_key, b_key, c_key, d_key;

  conn_table #(.HASH_LEN(HASH_LEN)) dut (
    .clk          (clk),
    .reset        (reset),
    .tuple_data_i (tuple_data_i),
    .tuple_valid_i(tuple_valid_i),
    .conn_data_o  (conn_data_o),
    .conn_valid_o (conn_valid_o),
    .lookup_cnt   (lookup_cnt),
    .insert_cnt   (insert_cnt),
    .full_cnt     (full_cnt)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Rising-edge counter used to time-stamp results.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Pop the oldest expectation on every strobe and compare id and timing.
  always @(negedge clk) begin
    if (conn_valid_o) begin
      strobes++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_strobe: got conn_data_o=%0h, expected no strobe", conn_data_o);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("strobe_data", 32'(conn_data_o), 32'(mon_e.data));
        checkOutput("strobe_cycle", cyc, mon_e.due);
      end
    end
  end

  task automatic waitStrobe(input int bound);
    int n = 0;
    while (!conn_valid_o && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (!conn_valid_o) begin
      tests++;
      fails++;
      $display("[TB] FAIL strobe_timeout: got no strobe in %0d cycles, expected one", bound);
    end
  endtask

  task automatic applyStimulus(input logic [103:0] key, input logic [15:0] exp_data,
                               input int lat, input int hold_extra);
    @(negedge clk);
    tuple_data_i  = {24'hABCDEF, key};
    tuple_valid_i = 1'b1;
    exp_q.push_back('{data: exp_data, due: cyc + 1 + lat});
    @(negedge clk);
    tuple_data_i = {24'h0, ~key};
    waitStrobe(lat + 5);
    repeat (hold_extra) @(negedge clk);
    tuple_valid_i = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Hard stop in case something never returns.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got no finish, expected bench completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios with hand-computed ids (HASH_LEN = 6, 64 entries).
  initial begin
    a_key = 104'd63;
    b_key = 104'h107F;
    c_key = 104'd5;
    d_key = '0;
    d_key[103] = 1'b1;

    #3;
    checkOutput("reset_valid", 32'(conn_valid_o), 32'd0);
    checkOutput("reset_data", 32'(conn_data_o), 32'd0);
    checkOutput("reset_lookup", lookup_cnt, 32'd0);
    checkOutput("reset_insert", insert_cnt, 32'd0);
    checkOutput("reset_full", full_cnt, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    applyStimulus(a_key, 16'd63, 2, 0);
    checkOutput("s1_lookup", lookup_cnt, 32'd1);
    checkOutput("s1_insert", insert_cnt, 32'd1);

    applyStimulus(a_key, 16'd63, 2, 0);
    checkOutput("s2_lookup", lookup_cnt, 32'd2);
    checkOutput("s2_insert", insert_cnt, 32'd1);

    strobes_before = strobes;
    applyStimulus(a_key, 16'd63, 2, 10);
    checkOutput("s5_strobes", strobes - strobes_before, 32'd1);
    checkOutput("s5_lookup", lookup_cnt, 32'd3);

    applyStimulus(b_key, 16'd0, 3, 0);
    checkOutput("s3_insert", insert_cnt, 32'd2);
    checkOutput("s3_lookup", lookup_cnt, 32'd4);

    applyStimulus(d_key, 16'd2, 2, 0);
    checkOutput("toppad_insert", insert_cnt, 32'd3);
    repeat (3) @(negedge clk);
    checkOutput("data_hold", 32'(conn_data_o), 32'd2);

    @(negedge clk);
    tuple_data_i  = {24'h0, c_key};
    tuple_valid_i = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("s6_async_valid", 32'(conn_valid_o), 32'd0);
    checkOutput("s6_async_data", 32'(conn_data_o), 32'd0);
    checkOutput("s6_async_lookup", lookup_cnt, 32'd0);
    checkOutput("s6_async_insert", insert_cnt, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    exp_q.push_back('{data: 16'd5, due: cyc + 3});
    waitStrobe(10);
    tuple_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("s6_insert", insert_cnt, 32'd1);
    checkOutput("s6_lookup", lookup_cnt, 32'd1);

    doReset();
    for (int i = 0; i < 64; i++) begin
      applyStimulus(104'(i), 16'(i), 2, 0);
    end
    checkOutput("s4_fill_insert", insert_cnt, 32'd64);
    applyStimulus(104'd64, 16'hFFFF, 65, 0);
    checkOutput("s4_full_cnt", full_cnt, 32'd1);
    checkOutput("s4_full_insert", insert_cnt, 32'd64);
    checkOutput("s4_full_lookup", lookup_cnt, 32'd65);
    checkOutput("s4_full_hold", 32'(conn_data_o), 32'hFFFF);
    for (int i = 0; i < 64; i++) begin
      applyStimulus(104'(i), 16'(i), 2, 0);
    end
    checkOutput("s4_final_lookup", lookup_cnt, 32'd129);
    checkOutput("s4_final_insert", insert_cnt, 32'd64);
    checkOutput("s4_final_full", full_cnt, 32'd1);

    repeat (4) @(negedge clk);
    checkOutput("scoreboard_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/conn_table.md
CONN_TABLE -- requirements
Module: conn_table

Interface
REQ-001 The block SHALL have parameter HASH_LEN, default 6, setting the table depth to 2^HASH_LEN entries; legal range is 1..16.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port tuple_data_i, input, 128 bits: {24'h0, src_ip[31:0], dst_ip[31:0], src_port[15:0], dst_port[15:0], protocol[7:0]}; key = bits [103:0], bits [127:104] ignored.
REQ-005 The block SHALL have port tuple_valid_i, input, 1 bit: level request, held high by the parser until it sees conn_valid_o.
REQ-006 The block SHALL have port conn_data_o, output, 16 bits: connection id, zero-extended table index, or 16'hFFFF when the table is full.
REQ-007 The block SHALL have port conn_valid_o, output, 1 bit: single-cycle result strobe.
REQ-008 The block SHALL have ports lookup_cnt, insert_cnt and full_cnt, each output, 32 bits: counters of requests, new entries and table-full failures.

Function
REQ-009 The block SHALL hold a table of 2^HASH_LEN entries; each entry is a valid bit plus a 104-bit key.
REQ-010 Hash: the key SHALL be split into HASH_LEN-bit chunks from bit 0 upward, the top chunk zero-padded, and all chunks XORed; the result is the start index h.
REQ-011 FSM states SHALL be IDLE, HASH, PROBE and RELEASE.
REQ-012 IDLE: when tuple_valid_i=1, the block SHALL latch the key, increment lookup_cnt, clear probe_cnt and go to HASH; otherwise it stays in IDLE.
REQ-013 HASH: the block SHALL register idx=h and go to PROBE.
REQ-014 PROBE, one entry per cycle, hit (entry valid and key equal): conn_data_o<=idx, conn_valid_o<=1, go to RELEASE.
REQ-015 PROBE, empty entry: the block SHALL write the key, set valid, increment insert_cnt, set conn_data_o<=idx and conn_valid_o<=1, then go to RELEASE.
REQ-016 PROBE, occupied non-matching entry: idx<=idx+1 modulo 2^HASH_LEN (63 wraps to 0) and probe_cnt<=probe_cnt+1.
REQ-017 PROBE, table full: if the 2^HASH_LEN-th probe also misses, the block SHALL set conn_data_o<=16'hFFFF and conn_valid_o<=1, increment full_cnt, leave the table unchanged and go to RELEASE.
REQ-018 Latency: for a result on probe N (N=1 is the first probe), conn_valid_o SHALL rise on the (N+1)th rising edge after the edge that sampled tuple_valid_i, and stay high exactly 1 cycle.
REQ-019 RELEASE: conn_valid_o<=0; the block SHALL stay in RELEASE while tuple_valid_i=1 and go to IDLE when it is 0, so a still-high request never starts a second lookup.
REQ-020 conn_data_o SHALL hold its last value until the next result.
REQ-021 tuple_data_i changes outside IDLE SHALL be ignored, because the key is latched.
REQ-022 The counters SHALL wrap modulo 2^32 without saturation.
REQ-023 There is no entry deletion or aging; entries are cleared only by reset.

Reset
REQ-024 reset=0 SHALL immediately clear, regardless of clk: FSM to IDLE, all valid bits, conn_valid_o=0, conn_data_o=0, all counters=0, idx=0 and probe_cnt=0.
REQ-025 Reset during HASH or PROBE SHALL abort the lookup with no strobe and no partial insert visible afterwards.
REQ-026 After reset deasserts, a request already held high SHALL be served as a new lookup from IDLE.

Verification
REQ-027 Scenario 1: reset, then tuple A held high -> one-cycle conn_valid_o on the 2nd edge; conn_data_o=hash(A); lookup_cnt=1, insert_cnt=1.
REQ-028 Scenario 2: tuple A again -> same id after 2 edges; lookup_cnt=2, insert_cnt=1.
REQ-029 Scenario 3: tuple B with hash(B)=hash(A)=63 -> conn_data_o=0 (wrap) after 3 edges; insert_cnt=2.
REQ-030 Scenario 4: insert 64 distinct tuples, then a 65th -> conn_data_o=16'hFFFF on the 65th edge; full_cnt=1; the earlier 64 ids are still returned on lookup.
REQ-031 Scenario 5: tuple_valid_i held high 10 cycles after the strobe -> exactly one strobe and lookup_cnt increments by 1.
REQ-032 Scenario 6: reset pulsed during PROBE of tuple C -> no strobe and counters=0; re-request C -> insert at hash(C), insert_cnt=1.
